// File: rtl/canny_pkg.sv
// Shared Canny types: pixel class encoding, hysteresis FSM states, edge-map levels
// and the strong/weak/none classifier.
package canny_pkg;

    typedef enum logic [1:0] {
        CLS_NONE   = 2'd0,
        CLS_WEAK   = 2'd1,
        CLS_STRONG = 2'd2
    } pix_class_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } hyst_state_t;

    localparam logic [7:0] EDGE_ON  = 8'hFF;
    localparam logic [7:0] EDGE_OFF = 8'h00;

    // Zero is always NONE; with lo > hi the WEAK band is empty and the hi test wins.
    function automatic pix_class_t classify(input logic [7:0] mag, input logic [7:0] lo,
                                            input logic [7:0] hi);
        if (mag == 8'd0)
            return CLS_NONE;
        else if (mag >= hi)
            return CLS_STRONG;
        else if (mag >= lo)
            return CLS_WEAK;
        return CLS_NONE;
    endfunction

endpackage

// File: rtl/class_line_buffer.sv
// One line of 2-bit pixel classes: one write port, one synchronous read port.
// A same-cycle read and write of one address returns the old entry.
module class_line_buffer
    import canny_pkg::*;
#(
    parameter int DEPTH = 640,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output pix_class_t    o_rdata,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  pix_class_t    i_wdata
);

    pix_class_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
        if (i_re)
            o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/hysteresis_threshold.sv
// Canny hysteresis: classify, 3x3 class window over two line buffers, promote weak
// pixels beside a strong one. HYST_STATS_EN adds the per-frame edge_count output.
module hysteresis_threshold
    import canny_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] edge_in,
    input  logic       pixel_in_valid,
    input  logic [7:0] thr_low,
    input  logic [7:0] thr_high,
    output logic [7:0] edge_out,
    output logic       pixel_out_valid,
    output logic       busy,
    output logic       overrun
`ifdef HYST_STATS_EN
    ,output logic [31:0] edge_count
`endif
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT + 2);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] COL_ONE  = CW'(1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_END  = RW'(IMG_HEIGHT + 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);

    hyst_state_t r_state, w_state_nxt;
    logic [CW-1:0] r_col_in, r_col_s1, r_ocol;
    logic [RW-1:0] r_row_in, r_orow;
    logic [7:0]    r_thr_lo, r_thr_hi, w_thr_lo, w_thr_hi;
    logic          w_run_acc, w_flush, w_beat, w_first, w_last_in, w_flush_done, w_prime;
    logic          r_beat_s1;
    logic [1:0]    r_vld_pipe;
    pix_class_t    w_cls, r_cls, w_lb0_q, w_lb1_q;
    pix_class_t    r_win_top [3];
    pix_class_t    r_win_mid [3];
    pix_class_t    r_win_bot [3];
    logic          w_m_top, w_m_bot, w_m_l, w_m_r, w_nb_strong, w_edge, w_last_out;

    // Flush beats keep advancing the beat counters into rows H and H+1.
    assign w_run_acc    = (r_state == ST_RUN) && pixel_in_valid;
    assign w_flush      = (r_state == ST_FLUSH);
    assign w_beat       = w_run_acc || w_flush;
    assign w_first      = w_run_acc && (r_col_in == '0) && (r_row_in == '0);
    assign w_last_in    = w_run_acc && (r_col_in == COL_LAST) && (r_row_in == ROW_LAST);
    assign w_flush_done = w_flush && (r_row_in == ROW_END);
    assign w_prime      = (r_row_in > ROW_ONE) || ((r_row_in == ROW_ONE) && (r_col_in != '0));
    assign w_thr_lo     = w_first ? thr_low  : r_thr_lo;
    assign w_thr_hi     = w_first ? thr_high : r_thr_hi;
    assign w_cls        = w_run_acc ? classify(edge_in, w_thr_lo, w_thr_hi) : CLS_NONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_RUN;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:   if (w_last_in)    w_state_nxt = ST_FLUSH;
            ST_FLUSH: if (w_flush_done) w_state_nxt = ST_RUN;
            default:                    w_state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        if (r_state == ST_FLUSH)
            busy = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col_in <= '0;
            r_row_in <= '0;
            r_thr_lo <= '0;
            r_thr_hi <= '0;
            overrun  <= 1'b0;
        end else begin
            if (w_flush && pixel_in_valid)
                overrun <= 1'b1;
            if (w_first) begin
                r_thr_lo <= thr_low;
                r_thr_hi <= thr_high;
            end
            if (w_beat) begin
                if (w_flush_done) begin
                    r_col_in <= '0;
                    r_row_in <= '0;
                end else if (r_col_in == COL_LAST) begin
                    r_col_in <= '0;
                    r_row_in <= r_row_in + ROW_ONE;
                end else begin
                    r_col_in <= r_col_in + COL_ONE;
                end
            end
        end
    end

    class_line_buffer #(.DEPTH(IMG_WIDTH), .AW(CW)) u_lb0 (
        .clk(clk), .i_re(w_beat), .i_raddr(r_col_in), .o_rdata(w_lb0_q),
        .i_we(r_beat_s1), .i_waddr(r_col_s1), .i_wdata(r_cls)
    );

    class_line_buffer #(.DEPTH(IMG_WIDTH), .AW(CW)) u_lb1 (
        .clk(clk), .i_re(w_beat), .i_raddr(r_col_in), .o_rdata(w_lb1_q),
        .i_we(r_beat_s1), .i_waddr(r_col_s1), .i_wdata(w_lb0_q)
    );

    // Column 2 is the newest beat; rows are (r-2, r-1, r) of that beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cls      <= CLS_NONE;
            r_col_s1   <= '0;
            r_beat_s1  <= 1'b0;
            r_vld_pipe <= '0;
            for (int i = 0; i < 3; i++) begin
                r_win_top[i] <= CLS_NONE;
                r_win_mid[i] <= CLS_NONE;
                r_win_bot[i] <= CLS_NONE;
            end
        end else begin
            r_beat_s1  <= w_beat;
            r_vld_pipe <= {r_vld_pipe[0], w_beat && w_prime};
            if (w_beat) begin
                r_cls    <= w_cls;
                r_col_s1 <= r_col_in;
            end
            if (r_beat_s1) begin
                r_win_top <= '{r_win_top[1], r_win_top[2], w_lb1_q};
                r_win_mid <= '{r_win_mid[1], r_win_mid[2], w_lb0_q};
                r_win_bot <= '{r_win_bot[1], r_win_bot[2], r_cls};
            end
        end
    end

    // Masks keep image-edge neighbours out, including columns from the adjacent line.
    assign w_m_top = (r_orow != '0);
    assign w_m_bot = (r_orow != ROW_LAST);
    assign w_m_l   = (r_ocol != '0);
    assign w_m_r   = (r_ocol != COL_LAST);

    assign w_nb_strong =
        (w_m_top && ((w_m_l && r_win_top[0] == CLS_STRONG) || (r_win_top[1] == CLS_STRONG) ||
                     (w_m_r && r_win_top[2] == CLS_STRONG))) ||
        (w_m_l && r_win_mid[0] == CLS_STRONG) || (w_m_r && r_win_mid[2] == CLS_STRONG) ||
        (w_m_bot && ((w_m_l && r_win_bot[0] == CLS_STRONG) || (r_win_bot[1] == CLS_STRONG) ||
                     (w_m_r && r_win_bot[2] == CLS_STRONG)));

    assign w_edge     = (r_win_mid[1] == CLS_STRONG) || ((r_win_mid[1] == CLS_WEAK) && w_nb_strong);
    assign w_last_out = (r_ocol == COL_LAST) && (r_orow == ROW_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_out        <= EDGE_OFF;
            pixel_out_valid <= 1'b0;
            r_ocol          <= '0;
            r_orow          <= '0;
        end else begin
            pixel_out_valid <= r_vld_pipe[1];
            if (r_vld_pipe[1]) begin
                edge_out <= w_edge ? EDGE_ON : EDGE_OFF;
                if (w_last_out) begin
                    r_ocol <= '0;
                    r_orow <= '0;
                end else if (r_ocol == COL_LAST) begin
                    r_ocol <= '0;
                    r_orow <= r_orow + ROW_ONE;
                end else begin
                    r_ocol <= r_ocol + COL_ONE;
                end
            end
        end
    end

`ifdef HYST_STATS_EN
    logic [31:0] r_edge_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_edge_cnt <= '0;
            edge_count <= '0;
        end else if (r_vld_pipe[1]) begin
            if (w_last_out) begin
                edge_count <= r_edge_cnt + 32'(w_edge);
                r_edge_cnt <= '0;
            end else begin
                r_edge_cnt <= r_edge_cnt + 32'(w_edge);
            end
        end
    end
`endif

endmodule

// File: tb/tb_hysteresis_threshold.sv
// Directed bench for hysteresis_threshold at 8x4; hand-built expected edge maps.
// Build with HYST_STATS_EN defined to also check edge_count.
module tb_hysteresis_threshold;

    localparam int W = 8;
    localparam int H = 4;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] edge_in;
    logic       pixel_in_valid;
    logic [7:0] thr_low, thr_high;
    logic [7:0] edge_out;
    logic       pixel_out_valid, busy, overrun;
`ifdef HYST_STATS_EN
    logic [31:0] edge_count;
`endif

    hysteresis_threshold #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst(rst), .edge_in(edge_in), .pixel_in_valid(pixel_in_valid),
        .thr_low(thr_low), .thr_high(thr_high), .edge_out(edge_out),
        .pixel_out_valid(pixel_out_valid), .busy(busy), .overrun(overrun)
`ifdef HYST_STATS_EN
        ,.edge_count(edge_count)
`endif
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         busy_cnt = 0;
    logic [7:0] q[$];
    logic [7:0] img [N];
    logic [7:0] exp_map [N];

    always @(negedge clk) begin
        if (pixel_out_valid) q.push_back(edge_out);
        if (busy) busy_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        for (int i = 0; i < N; i++) begin
            img[i]     = 8'd0;
            exp_map[i] = 8'h00;
        end
    endtask

    // lo/hi are presented on pixel 0 only; lo2/hi2 on the rest of the frame.
    task automatic run_frame(input logic [7:0] lo, input logic [7:0] hi,
                             input logic [7:0] lo2, input logic [7:0] hi2, input bit poke);
        q.delete();
        busy_cnt = 0;
        for (int i = 0; i < N; i++) begin
            edge_in        = img[i];
            pixel_in_valid = 1'b1;
            thr_low        = (i == 0) ? lo : lo2;
            thr_high       = (i == 0) ? hi : hi2;
            @(posedge clk); #1;
        end
        pixel_in_valid = poke;
        edge_in        = 8'd77;
        @(posedge clk); #1;
        pixel_in_valid = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (q.size() >= N && !busy) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_frame(input string tag);
        chk({tag, ".count"}, q.size(), N);
        for (int i = 0; i < N; i++)
            chk($sformatf("%s[%0d]", tag, i), (i < q.size()) ? {24'd0, q[i]} : 32'h100,
                {24'd0, exp_map[i]});
    endtask

    initial begin
        rst = 1'b1; edge_in = 8'd0; pixel_in_valid = 1'b0; thr_low = 8'd0; thr_high = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.edge_out", edge_out, 8'h00);
        chk("rst.valid", pixel_out_valid, 1'b0);
        chk("rst.busy", busy, 1'b0);
        chk("rst.overrun", overrun, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        clr();
        for (int i = 0; i < N; i++) begin img[i] = 8'd200; exp_map[i] = 8'hFF; end
        run_frame(8'd50, 8'd100, 8'd50, 8'd100, 1'b0);
        check_frame("all200");
        chk("all200.busy_cycles", busy_cnt, 9);
        chk("all200.overrun", overrun, 1'b0);
`ifdef HYST_STATS_EN
        chk("all200.edge_count", edge_count, 32);
`endif

        clr();
        img[11] = 8'd60;
        run_frame(8'd50, 8'd100, 8'd50, 8'd100, 1'b0);
        check_frame("lone_weak");

        img[20] = 8'd150; exp_map[11] = 8'hFF; exp_map[20] = 8'hFF;
        run_frame(8'd50, 8'd100, 8'd50, 8'd100, 1'b0);
        check_frame("weak_promoted");

        run_frame(8'd50, 8'd100, 8'd250, 8'd255, 1'b0);
        check_frame("thr_latched");

        clr();
        img[7] = 8'd150; img[8] = 8'd60; exp_map[7] = 8'hFF;
        run_frame(8'd50, 8'd100, 8'd50, 8'd100, 1'b0);
        check_frame("no_wrap");

        clr();
        img[18] = 8'd110; img[26] = 8'd90; exp_map[18] = 8'hFF;
        run_frame(8'd120, 8'd100, 8'd120, 8'd100, 1'b0);
        check_frame("thr_swapped");

        // Threshold equality, corners, and a weak at (2,7) beside strong (3,0) across the wrap.
        clr();
        img[0] = 8'd100; img[1] = 8'd50; img[9] = 8'd49; img[31] = 8'd50;
        img[24] = 8'd100; img[23] = 8'd50;
        exp_map[0] = 8'hFF; exp_map[1] = 8'hFF; exp_map[24] = 8'hFF;
        run_frame(8'd50, 8'd100, 8'd50, 8'd100, 1'b0);
        check_frame("bounds");

        clr();
        for (int i = 0; i < N; i++) begin img[i] = 8'd200; exp_map[i] = 8'hFF; end
        run_frame(8'd50, 8'd100, 8'd50, 8'd100, 1'b1);
        chk("poke.overrun", overrun, 1'b1);
        check_frame("poke");
        run_frame(8'd50, 8'd100, 8'd50, 8'd100, 1'b0);
        chk("poke.overrun_held", overrun, 1'b1);

        clr();
        img[11] = 8'd60; img[20] = 8'd150; exp_map[11] = 8'hFF; exp_map[20] = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            edge_in = img[i]; pixel_in_valid = 1'b1; thr_low = 8'd50; thr_high = 8'd100;
            @(posedge clk); #1;
        end
        pixel_in_valid = 1'b0;
        rst = 1'b1;
        q.delete();
        repeat (4) @(negedge clk);
        chk("midrst.outputs", q.size(), 0);
        chk("midrst.valid", pixel_out_valid, 1'b0);
        chk("midrst.busy", busy, 1'b0);
        chk("midrst.overrun", overrun, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        run_frame(8'd50, 8'd100, 8'd50, 8'd100, 1'b0);
        check_frame("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
